// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between requesters, the round-robin arbiter and the async FIFO write side.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  wr_full;
  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        active_id;
  logic [NREQ-1:0]       ack;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_data_in;

  modport master (
    input  req, req_data, wr_full,
    output grant, active_id, ack, fifo_wr_en, fifo_data_in
  );

  modport slave (
    output req, req_data, wr_full,
    input  grant, active_id, ack, fifo_wr_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NREQ requesters.
// state | meaning
// IDLE  | no owner; pick next requester after last_q
// GRANT | owner active_id_q may write up to BURST words
module fifo_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic               wr_clk,
  input  logic               reset,
  fifo_wr_arbiter_if.master  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(BURST) + 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDW-1:0]   active_id_q, active_id_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [IDW-1:0]   pick;
  logic             pick_vld;
  logic             fire;
  logic [NREQ-1:0]  ack;
  logic             wr_en;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] slice [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign slice[g] = bus.req_data[g*WIDTH +: WIDTH];
  end

  // First requesting index scanning last_q+1, last_q+2, ... modulo NREQ.
  always_comb begin : rr_pick
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!pick_vld && bus.req[IDW'(idx)]) begin
        pick     = IDW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign fire = (state_q == GRANT) && bus.req[active_id_q] && !bus.wr_full;

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      active_id_q <= '0;
      cnt_q       <= '0;
      last_q      <= IDW'(NREQ - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      active_id_q <= active_id_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    active_id_d = active_id_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d     = GRANT;
          grant_d     = NREQ'(1) << pick;
          active_id_d = pick;
          cnt_d       = '0;
        end
      end
      GRANT: begin
        // A full FIFO with the request held falls through: grant and count frozen.
        if ((fire && cnt_q == CW'(BURST - 1)) || !bus.req[active_id_q]) begin
          state_d     = IDLE;
          grant_d     = '0;
          active_id_d = '0;
          cnt_d       = '0;
          last_d      = active_id_q;
        end else if (fire) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en = fire;
    ack   = fire ? grant_q : '0;
    data  = '0;
    if (state_q == GRANT) data = slice[active_id_q];
  end

  assign bus.grant        = grant_q;
  assign bus.active_id    = active_id_q;
  assign bus.ack          = ack;
  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_data_in = data;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed plus randomized bench for fifo_wr_arbiter against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic wr_clk = 1'b0;
  logic reset  = 1'b1;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .wr_clk (wr_clk),
    .reset  (reset),
    .bus    (bus.master)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  // model: owner -1 means nobody holds the port
  int m_owner = -1;
  int m_words = 0;
  int m_last  = NREQ - 1;

  logic [WIDTH-1:0] dat [NREQ];
  int               kw   [NREQ];
  int               nacc [NREQ];
  bit               rnd_data = 1'b0;
  logic [WIDTH-1:0] wq [$];
  int               gq [$];
  logic [NREQ-1:0]  prev_grant = '0;
  logic [NREQ-1:0]  last_ack   = '0;
  int               n0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = dat[i];
  endtask

  task automatic step();
    logic [NREQ-1:0]  eg;
    logic [NREQ-1:0]  ea;
    logic [WIDTH-1:0] ed;
    logic             ef;
    @(negedge wr_clk);
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    ef = (m_owner >= 0) && bus.req[m_owner] && !bus.wr_full;
    ea = ef ? eg : '0;
    ed = (m_owner >= 0) ? dat[m_owner] : '0;
    check_eq("grant", bus.grant, eg);
    check_eq("active_id", bus.active_id, (m_owner < 0) ? 0 : m_owner);
    check_eq("wr_en", bus.fifo_wr_en, ef);
    check_eq("ack", bus.ack, ea);
    check_eq("data", bus.fifo_data_in, ed);
    last_ack = bus.ack;
    if (bus.fifo_wr_en) wq.push_back(bus.fifo_data_in);
    if (bus.grant != '0 && prev_grant == '0) gq.push_back(int'(bus.active_id));
    prev_grant = bus.grant;
    for (int i = 0; i < NREQ; i++) if (bus.ack[i]) nacc[i]++;
    @(posedge wr_clk);
    if (reset) begin
      m_owner = -1;
      m_words = 0;
      m_last  = NREQ - 1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (bus.req[c]) begin
          m_owner = c;
          m_words = 0;
          break;
        end
      end
    end else if (ef) begin
      m_words++;
      if (m_words == BURST) begin
        m_last  = m_owner;
        m_owner = -1;
        m_words = 0;
      end
    end else if (!bus.req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
      m_words = 0;
    end
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (last_ack[i]) begin
        kw[i]++;
        dat[i] = rnd_data ? WIDTH'($urandom) : WIDTH'(i*16 + kw[i]);
      end
    end
    drive_data();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.req     = '0;
    bus.wr_full = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      kw[i]   = 0;
      nacc[i] = 0;
      dat[i]  = WIDTH'(i*16);
    end
    drive_data();
    wq.delete();
    gq.delete();
    prev_grant = '0;
    last_ack   = '0;
  endtask

  initial begin
    bus.req     = '1;
    bus.wr_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      kw[i]   = 0;
      nacc[i] = 0;
      dat[i]  = WIDTH'(i*16);
    end
    drive_data();
    @(posedge wr_clk);
    #1;

    // reset held with everyone requesting
    repeat (3) begin
      step();
      check_eq("rst_grant", bus.grant, 0);
      check_eq("rst_wren", bus.fifo_wr_en, 0);
    end
    reset = 1'b0;
    step();
    check_eq("rst_first_grant", bus.grant, 4'b0001);

    // round robin, all requesting
    wq.delete();
    gq.delete();
    prev_grant = '0;
    repeat (20) step();
    check_eq("rr_words", wq.size(), 16);
    for (int j = 0; j < 16 && j < wq.size(); j++)
      check_eq("rr_data", wq[j], (j / 4) * 16 + (j % 4));
    step();
    check_eq("rr_grants", gq.size(), 5);
    for (int j = 0; j < 5 && j < gq.size(); j++)
      check_eq("rr_order", gq[j], j % 4);

    // full stall on requester 1
    do_reset();
    bus.req = 4'b0010;
    step();
    for (int t = 0; t < 10 && wq.size() < 2; t++) step();
    check_eq("stall_pre_words", wq.size(), 2);
    bus.wr_full = 1'b1;
    repeat (5) begin
      step();
      check_eq("stall_grant", bus.grant, 4'b0010);
    end
    check_eq("stall_nowrite", wq.size(), 2);
    bus.wr_full = 1'b0;
    n0 = wq.size();
    for (int t = 0; t < 8 && bus.grant != '0; t++) step();
    check_eq("stall_more", wq.size() - n0, 2);
    check_eq("stall_release", bus.grant, 0);

    // early drop by requester 2 with 3 waiting
    do_reset();
    bus.req = 4'b1100;
    step();
    check_eq("drop_grant2", bus.grant, 4'b0100);
    step();
    bus.req = 4'b1000;
    step();
    check_eq("drop_release", bus.grant, 0);
    step();
    check_eq("drop_next", bus.grant, 4'b1000);
    check_eq("drop_words", nacc[2], 1);

    // single requester
    do_reset();
    bus.req = 4'b1000;
    repeat (20) begin
      step();
      check_eq("single_grant", (bus.grant == 4'b0000) || (bus.grant == 4'b1000), 1);
    end
    check_eq("single_words", nacc[3], 16);

    // reset after the 2nd word of a burst
    do_reset();
    bus.req = 4'b1110;
    step();
    for (int t = 0; t < 10 && wq.size() < 2; t++) step();
    reset = 1'b1;
    step();
    check_eq("midrst_grant", bus.grant, 0);
    check_eq("midrst_wren", bus.fifo_wr_en, 0);
    check_eq("midrst_ack", bus.ack, 0);
    reset   = 1'b0;
    bus.req = 4'b1111;
    step();
    check_eq("midrst_restart", bus.grant, 4'b0001);

    // randomized traffic, full and occasional reset
    do_reset();
    rnd_data = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req[i] || last_ack[i]) bus.req[i] = ($urandom_range(0, 3) != 0);
      bus.wr_full = ($urandom_range(0, 3) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
